// File: rtl/diffusion_step_worker.sv
`default_nettype none
// ============================================================================
// Module      : diffusion_step_worker
// Description : Follows the shared step counter and, for each step, streams
//               that step's work items to the engine over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module diffusion_step_worker #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_STEPS  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] l_step,
    input  logic [ADDR_WIDTH-1:0] num_items,
    output logic                  step_start,
    output logic                  item_valid,
    output logic [ADDR_WIDTH-1:0] item_addr,
    input  logic                  item_ready,
    output logic                  finished,
    output logic [DATA_WIDTH-1:0] step_idx,
    output logic                  all_done,
    output logic                  seq_err
);

    localparam logic [DATA_WIDTH-1:0] c_max_steps = DATA_WIDTH'(MAX_STEPS);
    localparam logic [DATA_WIDTH-1:0] c_step_one  = DATA_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ISSUE = 3'd2,
        S_DONE  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_cur_step;
    logic [DATA_WIDTH-1:0] w_cur_step_nxt;
    logic [DATA_WIDTH-1:0] w_cur_step_inc;
    logic [ADDR_WIDTH-1:0] r_item_cnt;
    logic [ADDR_WIDTH-1:0] w_item_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_target;
    logic [ADDR_WIDTH-1:0] w_target_nxt;
    logic                  r_seq_err;
    logic                  w_seq_err_nxt;
    logic                  w_clear;
    logic                  w_step_next;
    logic                  w_skip;
    logic                  w_transfer;

    assign w_cur_step_inc = r_cur_step + c_step_one;
    assign w_clear        = (l_step < r_cur_step);
    assign w_step_next    = (l_step == w_cur_step_inc);
    // Advancing while items are still owed means the counter missed this worker.
    assign w_skip         = (l_step > w_cur_step_inc) ||
                            (w_step_next && ((r_state == S_START) || (r_state == S_ISSUE)));
    assign w_transfer     = (r_state == S_ISSUE) && item_ready;

    assign step_start = (r_state == S_START);
    assign item_valid = (r_state == S_ISSUE);
    assign item_addr  = (r_state == S_ISSUE) ? r_item_cnt : '0;
    // Combinational on l_step so it drops in the very cycle the counter advances.
    assign finished   = (r_state == S_DONE) && (l_step == r_cur_step);
    assign step_idx   = r_cur_step;
    assign all_done   = (r_state == S_HALT);
    assign seq_err    = r_seq_err;

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_step_nxt = r_cur_step;
        w_item_cnt_nxt = r_item_cnt;
        w_target_nxt   = r_target;
        w_seq_err_nxt  = r_seq_err;

        if (w_clear) begin
            w_state_nxt    = S_IDLE;
            w_cur_step_nxt = '0;
            w_item_cnt_nxt = '0;
        end else if (w_skip) begin
            w_seq_err_nxt = 1'b1;
            w_state_nxt   = S_HALT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cur_step >= c_max_steps) begin
                        w_state_nxt = S_HALT;
                    end else if (l_step == r_cur_step) begin
                        w_state_nxt = S_START;
                    end
                end
                S_START: begin
                    w_target_nxt   = num_items;
                    w_item_cnt_nxt = '0;
                    w_state_nxt    = (num_items != '0) ? S_ISSUE : S_DONE;
                end
                S_ISSUE: begin
                    if (w_transfer) begin
                        w_item_cnt_nxt = r_item_cnt + c_addr_one;
                        if (r_item_cnt == (r_target - c_addr_one)) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (w_step_next) begin
                        w_cur_step_nxt = w_cur_step_inc;
                        w_state_nxt    = (w_cur_step_inc < c_max_steps) ? S_IDLE : S_HALT;
                    end
                end
                S_HALT: begin
                    w_state_nxt = S_HALT;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cur_step <= '0;
            r_item_cnt <= '0;
            r_target   <= '0;
            r_seq_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_step <= w_cur_step_nxt;
            r_item_cnt <= w_item_cnt_nxt;
            r_target   <= w_target_nxt;
            r_seq_err  <= w_seq_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_diffusion_step_worker.sv
`default_nettype none
// ============================================================================
// Module      : tb_diffusion_step_worker
// Description : Directed test-plan scenarios plus randomized counter traffic,
//               every cycle compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_diffusion_step_worker;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int MS = 7;

    localparam int MD_WAIT  = 0;
    localparam int MD_BEGIN = 1;
    localparam int MD_SEND  = 2;
    localparam int MD_END   = 3;
    localparam int MD_STOP  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] l_step = '0;
    logic [AW-1:0] num_items = '0;
    logic          item_ready = 1'b0;
    logic          step_start;
    logic          item_valid;
    logic [AW-1:0] item_addr;
    logic          finished;
    logic [DW-1:0] step_idx;
    logic          all_done;
    logic          seq_err;

    diffusion_step_worker #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_STEPS (MS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .l_step    (l_step),
        .num_items (num_items),
        .step_start(step_start),
        .item_valid(item_valid),
        .item_addr (item_addr),
        .item_ready(item_ready),
        .finished  (finished),
        .step_idx  (step_idx),
        .all_done  (all_done),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_start = 0;

    // Behavioural model: which phase of the step we are in, items owed/sent.
    int          m_mode;
    logic [31:0] m_cur;
    logic [31:0] m_sent;
    logic [31:0] m_total;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit model_finished();
        return (m_mode == MD_END) && (l_step == m_cur);
    endfunction

    task automatic model_reset();
        m_mode = MD_WAIT; m_cur = 0; m_sent = 0; m_total = 0; m_err = 0;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
        end else if (l_step < m_cur) begin
            m_mode = MD_WAIT; m_cur = 0; m_sent = 0;
        end else if (l_step > m_cur + 1 ||
                     (l_step == m_cur + 1 && (m_mode == MD_BEGIN || m_mode == MD_SEND))) begin
            m_err = 1; m_mode = MD_STOP;
        end else begin
            case (m_mode)
                MD_WAIT:  if (m_cur >= MS) m_mode = MD_STOP;
                          else if (l_step == m_cur) m_mode = MD_BEGIN;
                MD_BEGIN: begin
                    m_total = 32'(num_items); m_sent = 0;
                    m_mode  = (m_total == 0) ? MD_END : MD_SEND;
                end
                MD_SEND:  if (item_ready) begin
                    m_sent++;
                    if (m_sent == m_total) m_mode = MD_END;
                end
                MD_END:   if (l_step == m_cur + 1) begin
                    m_cur++;
                    m_mode = (m_cur < MS) ? MD_WAIT : MD_STOP;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_outputs();
        check("step_start", 32'(step_start), 32'(m_mode == MD_BEGIN));
        check("item_valid", 32'(item_valid), 32'(m_mode == MD_SEND));
        check("item_addr",  32'(item_addr),  (m_mode == MD_SEND) ? m_sent : 32'd0);
        check("finished",   32'(finished),   32'(model_finished()));
        check("step_idx",   step_idx,        m_cur);
        check("all_done",   32'(all_done),   32'(m_mode == MD_STOP));
        check("seq_err",    32'(seq_err),    32'(m_err));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_outputs();
        if (step_start === 1'b1) n_start++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wait_mode(input int mode, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (m_mode != mode && n < budget);
        if (m_mode != mode) check("wait_timeout", 32'(m_mode), 32'(mode));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        l_step = '0;
    endtask

    initial begin
        int pat[7];
        pat = '{1, 0, 0, 1, 1, 0, 1};

        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tick();                     // outputs held in reset

        // Basic step
        rst_n = 1'b1; l_step = 0; num_items = 3; item_ready = 1'b1;
        wait_mode(MD_END, 20);
        l_step = 1;                 // finished must drop this cycle

        // Backpressure on step 1
        num_items = 4;
        wait_mode(MD_SEND, 20);
        for (int i = 0; i < 7; i++) begin
            item_ready = pat[i][0];
            tick();
        end
        tick();

        // Clear in the middle of step 2
        l_step = 2; num_items = 5; item_ready = 1'b1;
        wait_mode(MD_SEND, 20);
        tick();
        l_step = 0;
        tick();

        // Empty step after the clear
        num_items = 0;
        wait_mode(MD_END, 20);
        tick();

        // Skip error from DONE at step 1
        l_step = 1; num_items = 2;
        wait_mode(MD_END, 20);
        l_step = 3;
        repeat (3) tick();
        l_step = 0;                 // clear leaves HALT, error stays sticky
        repeat (4) tick();
        do_reset();

        // Full run of all steps
        n_start = 0;
        for (int s = 0; s < MS; s++) begin
            num_items  = AW'($urandom_range(0, 3));
            item_ready = 1'b1;
            wait_mode(MD_END, 50);
            l_step = 32'(s + 1);
        end
        repeat (4) tick();
        check("full_run_starts", 32'(n_start), 32'(MS));
        check("full_run_halt", 32'(all_done), 32'd1);
        check("full_run_idx", step_idx, 32'(MS));

        // Randomized counter traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            item_ready = ($urandom_range(0, 3) != 0);
            num_items  = AW'($urandom_range(0, 5));
            rst_n      = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 199) == 0) l_step = 0;
            else if ($urandom_range(0, 499) == 0) l_step = l_step + 2;
            else if (model_finished() && $urandom_range(0, 9) < 7) l_step = m_cur + 1;
            else if (m_mode == MD_STOP && $urandom_range(0, 19) == 0) l_step = 0;
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
